vanilla_irq_ctrl: RTL and testbench

Interrupt-entry sequencer for the vanilla core, directly downstream of the machine CSR block. It consumes the registered mstatus.mie, mip and mie state, and decides when an interrupt is taken. It then drains the pipeline, redirects fetch to the handler, and produces the `interrupt_entered`, `mret_called` and `npc_r` inputs that the CSR block consumes. It sits between the CSR block and the fetch/EXE control in the vanilla core.

---
 rtl/bsg_vanilla_pkg.sv | 30 +++
 rtl/vanilla_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_vanilla_irq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types used by the CSR block and the interrupt-entry sequencer.
package bsg_vanilla_pkg;

    typedef struct packed {
        logic trace;
        logic remote;
    } csr_interrupt_vector_s;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_DRAIN   = 2'd1,
        IRQ_ENTER   = 2'd2,
        IRQ_HANDLER = 2'd3
    } vanilla_irq_state_e;

    // Remote wins over trace; returns a one-hot cause, or zero when nothing is armed.
    function automatic csr_interrupt_vector_s irq_select_cause(input csr_interrupt_vector_s armed);
        csr_interrupt_vector_s sel;
        sel = '{trace: 1'b0, remote: 1'b0};
        if (armed.remote) begin
            sel.remote = 1'b1;
        end else if (armed.trace) begin
            sel.trace = 1'b1;
        end else begin
            sel = '{trace: 1'b0, remote: 1'b0};
        end
        return sel;
    endfunction

endpackage

// File: rtl/vanilla_irq_ctrl.sv
// Interrupt-entry sequencer: decides when an interrupt is taken, drains the
// pipeline, redirects fetch to the handler and reports entry/mret to the CSR block.
module vanilla_irq_ctrl
    import bsg_vanilla_pkg::*;
#(
    parameter int pc_width_p      = 32,
    parameter int remote_vec_pc_p = 1,
    parameter int trace_vec_pc_p  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  mstatus_mie_i,
    input  csr_interrupt_vector_s mip_i,
    input  csr_interrupt_vector_s mie_i,
    input  logic [pc_width_p-1:0] mepc_i,
    input  logic [pc_width_p-1:0] npc_i,
    input  logic                  drained_i,
    input  logic                  stall_i,
    input  logic                  exe_mret_i,
    output logic                  hold_fetch_o,
    output logic                  interrupt_entered_o,
    output logic                  mret_called_o,
    output logic [pc_width_p-1:0] npc_r_o,
    output logic                  redirect_v_o,
    output logic [pc_width_p-1:0] redirect_pc_o,
    output csr_interrupt_vector_s cause_o,
    output logic                  in_handler_o
);

    localparam logic [pc_width_p-1:0] remote_vec_c = pc_width_p'(remote_vec_pc_p);
    localparam logic [pc_width_p-1:0] trace_vec_c  = pc_width_p'(trace_vec_pc_p);

    vanilla_irq_state_e    state_r;
    logic [pc_width_p-1:0] npc_r;
    csr_interrupt_vector_s cause_r;

    csr_interrupt_vector_s armed_s;
    csr_interrupt_vector_s sel_cause_s;
    logic                  pend_s;
    logic                  mret_fire_s;

    logic                  hold_fetch_s;
    logic                  interrupt_entered_s;
    logic                  mret_called_s;
    logic                  redirect_v_s;
    logic [pc_width_p-1:0] redirect_pc_s;
    logic                  in_handler_s;

    assign armed_s     = mip_i & mie_i;
    assign pend_s      = mstatus_mie_i & (|armed_s);
    assign sel_cause_s = irq_select_cause(armed_s);
    assign mret_fire_s = exe_mret_i & ~stall_i;

    // Output decode: Moore from the state, Mealy only for the mret redirect.
    always_comb begin
        hold_fetch_s        = 1'b0;
        interrupt_entered_s = 1'b0;
        mret_called_s       = 1'b0;
        redirect_v_s        = 1'b0;
        redirect_pc_s       = {pc_width_p{1'b0}};
        in_handler_s        = 1'b0;
        case (state_r)
            IRQ_IDLE, IRQ_DRAIN, IRQ_HANDLER: begin
                hold_fetch_s  = (state_r == IRQ_DRAIN);
                in_handler_s  = (state_r == IRQ_HANDLER);
                mret_called_s = mret_fire_s;
                redirect_v_s  = mret_fire_s;
                redirect_pc_s = mret_fire_s ? mepc_i : {pc_width_p{1'b0}};
            end
            IRQ_ENTER: begin
                hold_fetch_s        = 1'b1;
                interrupt_entered_s = 1'b1;
                redirect_v_s        = 1'b1;
                in_handler_s        = 1'b1;
                redirect_pc_s       = cause_r.remote ? remote_vec_c : trace_vec_c;
            end
            default: begin
                hold_fetch_s        = 1'b0;
                interrupt_entered_s = 1'b0;
            end
        endcase
    end

    // Sequencer state plus the return PC and cause captured on leaving DRAIN.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IRQ_IDLE;
            npc_r   <= {pc_width_p{1'b0}};
            cause_r <= '{trace: 1'b0, remote: 1'b0};
        end else begin
            case (state_r)
                IRQ_IDLE: begin
                    if (mret_fire_s) begin
                        state_r <= IRQ_IDLE;
                    end else if (pend_s) begin
                        state_r <= IRQ_DRAIN;
                    end else begin
                        state_r <= IRQ_IDLE;
                    end
                end
                IRQ_DRAIN: begin
                    if (mret_fire_s || !pend_s) begin
                        state_r <= IRQ_IDLE;
                    end else if (drained_i && !stall_i) begin
                        state_r <= IRQ_ENTER;
                        npc_r   <= npc_i;
                        cause_r <= sel_cause_s;
                    end else begin
                        state_r <= IRQ_DRAIN;
                    end
                end
                IRQ_ENTER: begin
                    state_r <= IRQ_HANDLER;
                end
                IRQ_HANDLER: begin
                    if (mret_fire_s) begin
                        state_r <= IRQ_IDLE;
                        cause_r <= '{trace: 1'b0, remote: 1'b0};
                    end else begin
                        state_r <= IRQ_HANDLER;
                    end
                end
                default: begin
                    state_r <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign hold_fetch_o        = hold_fetch_s;
    assign interrupt_entered_o = interrupt_entered_s;
    assign mret_called_o       = mret_called_s;
    assign redirect_v_o        = redirect_v_s;
    assign redirect_pc_o       = redirect_pc_s;
    assign in_handler_o        = in_handler_s;
    assign npc_r_o             = npc_r;
    assign cause_o             = cause_r;

endmodule

// File: tb/tb_vanilla_irq_ctrl.sv
// Directed bench for vanilla_irq_ctrl: entry latency, priority, drain stall,
// withdrawn interrupt, mret during drain and asynchronous reset in the handler.
module tb_vanilla_irq_ctrl;
    import bsg_vanilla_pkg::*;

    localparam int pc_width_p = 16;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i;
    logic                  mstatus_mie_i;
    csr_interrupt_vector_s mip_i;
    csr_interrupt_vector_s mie_i;
    logic [pc_width_p-1:0] mepc_i;
    logic [pc_width_p-1:0] npc_i;
    logic                  drained_i;
    logic                  stall_i;
    logic                  exe_mret_i;
    logic                  hold_fetch_o;
    logic                  interrupt_entered_o;
    logic                  mret_called_o;
    logic [pc_width_p-1:0] npc_r_o;
    logic                  redirect_v_o;
    logic [pc_width_p-1:0] redirect_pc_o;
    csr_interrupt_vector_s cause_o;
    logic                  in_handler_o;

    int err_cnt   = 0;
    int check_cnt = 0;

    vanilla_irq_ctrl #(
        .pc_width_p     (pc_width_p),
        .remote_vec_pc_p(1),
        .trace_vec_pc_p (2)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .mstatus_mie_i      (mstatus_mie_i),
        .mip_i              (mip_i),
        .mie_i              (mie_i),
        .mepc_i             (mepc_i),
        .npc_i              (npc_i),
        .drained_i          (drained_i),
        .stall_i            (stall_i),
        .exe_mret_i         (exe_mret_i),
        .hold_fetch_o       (hold_fetch_o),
        .interrupt_entered_o(interrupt_entered_o),
        .mret_called_o      (mret_called_o),
        .npc_r_o            (npc_r_o),
        .redirect_v_o       (redirect_v_o),
        .redirect_pc_o      (redirect_pc_o),
        .cause_o            (cause_o),
        .in_handler_o       (in_handler_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here apply to the new cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Run HANDLER -> mret -> IDLE with the global enable cleared, as the CSR block would.
    task automatic leave_handler(input string tag);
        mstatus_mie_i = 1'b0;
        exe_mret_i    = 1'b1;
        mepc_i        = 16'h0080;
        settle();
        check_eq({tag, "_mret_pulse"}, {31'd0, mret_called_o}, 32'd1);
        check_eq({tag, "_mret_pc"}, {16'd0, redirect_pc_o}, 32'h80);
        tick();
        exe_mret_i = 1'b0;
        settle();
        check_eq({tag, "_post_mret_cause"}, {30'd0, cause_o}, 32'd0);
        check_eq({tag, "_post_mret_inh"}, {31'd0, in_handler_o}, 32'd0);
    endtask

    initial begin
        reset_n_i     = 1'b0;
        mstatus_mie_i = 1'b0;
        mip_i         = 2'b00;
        mie_i         = 2'b00;
        mepc_i        = 16'h0000;
        npc_i         = 16'h0000;
        drained_i     = 1'b0;
        stall_i       = 1'b0;
        exe_mret_i    = 1'b0;
        #2;
        check_eq("rst_npc_r", {16'd0, npc_r_o}, 32'd0);
        check_eq("rst_cause", {30'd0, cause_o}, 32'd0);
        check_eq("rst_outs", {26'd0, hold_fetch_o, interrupt_entered_o, mret_called_o,
                              redirect_v_o, in_handler_o, |redirect_pc_o}, 32'd0);
        #20 reset_n_i = 1'b1;
        tick();

        // remote entry at minimum latency
        mie_i = 2'b01; mstatus_mie_i = 1'b1; mip_i = 2'b01; drained_i = 1'b1; npc_i = 16'h0040;
        settle();
        check_eq("rem_idle_hold", {31'd0, hold_fetch_o}, 32'd0);
        tick();
        check_eq("rem_drain_hold", {31'd0, hold_fetch_o}, 32'd1);
        check_eq("rem_drain_noentry", {31'd0, interrupt_entered_o}, 32'd0);
        tick();
        check_eq("rem_enter", {31'd0, interrupt_entered_o}, 32'd1);
        check_eq("rem_redir_v", {31'd0, redirect_v_o}, 32'd1);
        check_eq("rem_redir_pc", {16'd0, redirect_pc_o}, 32'd1);
        check_eq("rem_npc_r", {16'd0, npc_r_o}, 32'h40);
        check_eq("rem_cause", {30'd0, cause_o}, 32'd1);
        check_eq("rem_inh", {31'd0, in_handler_o}, 32'd1);
        check_eq("rem_enter_nomret", {31'd0, mret_called_o}, 32'd0);
        tick();
        check_eq("rem_hdl_inh", {31'd0, in_handler_o}, 32'd1);
        check_eq("rem_hdl_once", {31'd0, interrupt_entered_o}, 32'd0);
        check_eq("rem_hdl_hold", {31'd0, hold_fetch_o}, 32'd0);
        leave_handler("rem");

        // both pending: remote first, then trace alone
        mie_i = 2'b11; mip_i = 2'b11; mstatus_mie_i = 1'b1; npc_i = 16'h0050;
        tick();
        tick();
        check_eq("pri_cause", {30'd0, cause_o}, 32'd1);
        check_eq("pri_pc", {16'd0, redirect_pc_o}, 32'd1);
        tick();
        leave_handler("pri1");
        mip_i = 2'b10; mstatus_mie_i = 1'b1; npc_i = 16'h0060;
        tick();
        tick();
        check_eq("pri2_enter", {31'd0, interrupt_entered_o}, 32'd1);
        check_eq("pri2_cause", {30'd0, cause_o}, 32'd2);
        check_eq("pri2_pc", {16'd0, redirect_pc_o}, 32'd2);
        check_eq("pri2_npc_r", {16'd0, npc_r_o}, 32'h60);
        tick();
        leave_handler("pri2");

        // drain not complete for 5 cycles, then a stalled drained cycle
        mie_i = 2'b01; mip_i = 2'b01; mstatus_mie_i = 1'b1; drained_i = 1'b0; npc_i = 16'h0070;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq($sformatf("stl_hold%0d", i), {31'd0, hold_fetch_o}, 32'd1);
            check_eq($sformatf("stl_noent%0d", i), {31'd0, interrupt_entered_o}, 32'd0);
            tick();
        end
        drained_i = 1'b1; stall_i = 1'b1;
        tick();
        check_eq("stl_stall_hold", {31'd0, hold_fetch_o}, 32'd1);
        check_eq("stl_stall_noent", {31'd0, interrupt_entered_o}, 32'd0);
        stall_i = 1'b0;
        tick();
        check_eq("stl_enter", {31'd0, interrupt_entered_o}, 32'd1);
        check_eq("stl_npc_r", {16'd0, npc_r_o}, 32'h70);
        tick();
        leave_handler("stl");

        // pend withdrawn during DRAIN
        mip_i = 2'b01; mstatus_mie_i = 1'b1; drained_i = 1'b0;
        tick();
        check_eq("wd_drain_hold", {31'd0, hold_fetch_o}, 32'd1);
        mip_i = 2'b00;
        tick();
        check_eq("wd_release", {31'd0, hold_fetch_o}, 32'd0);
        check_eq("wd_noentry", {31'd0, interrupt_entered_o}, 32'd0);
        tick();
        check_eq("wd_noentry2", {31'd0, interrupt_entered_o}, 32'd0);
        check_eq("wd_inh", {31'd0, in_handler_o}, 32'd0);

        // mret while draining, then re-entry
        mip_i = 2'b01; drained_i = 1'b0;
        tick();
        exe_mret_i = 1'b1; mepc_i = 16'h0080;
        settle();
        check_eq("mrd_pulse", {31'd0, mret_called_o}, 32'd1);
        check_eq("mrd_redir_v", {31'd0, redirect_v_o}, 32'd1);
        check_eq("mrd_redir_pc", {16'd0, redirect_pc_o}, 32'h80);
        check_eq("mrd_noentry", {31'd0, interrupt_entered_o}, 32'd0);
        tick();
        exe_mret_i = 1'b0;
        settle();
        check_eq("mrd_idle_hold", {31'd0, hold_fetch_o}, 32'd0);
        check_eq("mrd_single", {31'd0, mret_called_o}, 32'd0);
        tick();
        check_eq("mrd_redrain", {31'd0, hold_fetch_o}, 32'd1);
        drained_i = 1'b1; npc_i = 16'h0090;
        tick();
        check_eq("mrd_reenter", {31'd0, interrupt_entered_o}, 32'd1);
        check_eq("mrd_npc_r", {16'd0, npc_r_o}, 32'h90);
        tick();
        check_eq("ar_pre_inh", {31'd0, in_handler_o}, 32'd1);

        // asynchronous reset mid-cycle in HANDLER
        #2 reset_n_i = 1'b0;
        mstatus_mie_i = 1'b0; mip_i = 2'b00;
        #1;
        check_eq("ar_inh", {31'd0, in_handler_o}, 32'd0);
        check_eq("ar_npc_r", {16'd0, npc_r_o}, 32'd0);
        check_eq("ar_cause", {30'd0, cause_o}, 32'd0);
        check_eq("ar_outs", {28'd0, hold_fetch_o, interrupt_entered_o, mret_called_o, redirect_v_o}, 32'd0);
        #15 reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("ar_nopulse%0d", i), {30'd0, interrupt_entered_o, mret_called_o}, 32'd0);
            check_eq($sformatf("ar_idle_inh%0d", i), {31'd0, in_handler_o}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
